// File: rtl/apb_spi_master_mcs_if.sv
// APB slave port bundle for apb_spi_master_mcs.
interface apb_spi_master_mcs_if;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_spi_master_mcs.sv
// APB-attached SPI master: configurable frame width, multiple chip selects,
// all four CPOL/CPHA modes, LSB/MSB-first, SCK divider, TX/RX FIFOs, irq.
module apb_spi_master_mcs #(
  parameter int DATA_W       = 8,
  parameter int NUM_CS       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_DEPTH_W = 2
) (
  input  logic                PCLK,
  input  logic                PRST,
  apb_spi_master_mcs_if.slave apb,
  output logic                sck,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_CS-1:0]   nss,
  output logic                irq
);
  localparam int PW = FIFO_DEPTH_W + 1;
  localparam logic [6:0] NUM_EDGES = 7'(2 * DATA_W);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  state_t state_reg, state_next;

  // Control/status registers
  logic [18:0] ctrl_reg;
  logic        rx_ovf_reg;
  logic        ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_lsb, ctrl_rxie, ctrl_txie;
  logic [7:0]  ctrl_div;
  logic [2:0]  ctrl_cs;

  assign ctrl_en   = ctrl_reg[0];
  assign ctrl_cpol = ctrl_reg[1];
  assign ctrl_cpha = ctrl_reg[2];
  assign ctrl_lsb  = ctrl_reg[3];
  assign ctrl_rxie = ctrl_reg[4];
  assign ctrl_txie = ctrl_reg[5];
  assign ctrl_div  = ctrl_reg[15:8];
  assign ctrl_cs   = ctrl_reg[18:16];

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0]     tx_wr_reg, tx_rd_reg, rx_wr_reg, rx_rd_reg;
  logic [PW-1:0]     tx_level, rx_level;
  logic              tx_full, tx_empty, rx_full, rx_empty;
  logic [DATA_W-1:0] tx_head, rx_head;

  // Shift engine
  logic [7:0]        cnt_reg, div_reg;
  logic [6:0]        edge_reg;
  logic              cpol_lat_reg, cpha_lat_reg, lsb_lat_reg;
  logic              sck_reg, mosi_reg;
  logic [NUM_CS-1:0] nss_reg, nss_dec;
  logic [DATA_W-1:0] tx_sh_reg, rx_sh_reg, tx_shifted, rx_shifted;
  logic              half_done, load, toggle, rx_push;
  logic              leading, do_sample, do_shift, mosi_shifted;

  // APB decode strobes
  logic              access, err, ctrl_we, ovf_clr, tx_push, rx_pop, busy, rx_accept;
  logic [2:0]        addr;
  logic [31:0]       prdata;
  logic              unused_bits;

  assign unused_bits = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA[31:19], apb.PWDATA[7:6]};

  assign tx_level = tx_wr_reg - tx_rd_reg;
  assign rx_level = rx_wr_reg - rx_rd_reg;
  assign tx_empty = (tx_wr_reg == tx_rd_reg);
  assign rx_empty = (rx_wr_reg == rx_rd_reg);
  assign tx_full  = (tx_wr_reg[PW-1] != tx_rd_reg[PW-1]) &&
                    (tx_wr_reg[PW-2:0] == tx_rd_reg[PW-2:0]);
  assign rx_full  = (rx_wr_reg[PW-1] != rx_rd_reg[PW-1]) &&
                    (rx_wr_reg[PW-2:0] == rx_rd_reg[PW-2:0]);
  assign tx_head  = tx_mem[tx_rd_reg[PW-2:0]];
  assign rx_head  = rx_mem[rx_rd_reg[PW-2:0]];
  assign busy     = (state_reg != IDLE);

  assign access = apb.PSEL & apb.PENABLE;
  assign addr   = apb.PADDR[4:2];

  // Chip-select decode; an out-of-range CS_SEL matches no output and leaves all high
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign nss_dec[gi] = (ctrl_cs != 3'(gi));
    end
  endgenerate

  // Register decode: read mux, error flag and side-effect strobes
  always_comb begin
    prdata  = '0;
    err     = 1'b0;
    ctrl_we = 1'b0;
    ovf_clr = 1'b0;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    if (access) begin
      case (addr)
        3'd0: begin
          if (apb.PWRITE) begin
            ctrl_we = 1'b1;
            err     = (32'(apb.PWDATA[18:16]) >= NUM_CS);
          end else begin
            prdata = 32'(ctrl_reg);
          end
        end
        3'd1: begin
          if (apb.PWRITE) begin
            ovf_clr = apb.PWDATA[5];
          end else begin
            prdata = {8'h00, 8'(rx_level), 8'(tx_level), 2'b00,
                      rx_ovf_reg, rx_empty, rx_full, tx_empty, tx_full, busy};
          end
        end
        3'd2: begin
          if (apb.PWRITE) begin
            // A full FIFO rejects the write even if the engine pops this cycle
            if (tx_full) err = 1'b1;
            else         tx_push = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        3'd3: begin
          if (apb.PWRITE) begin
            err = 1'b1;
          end else if (rx_empty) begin
            err = 1'b1;
          end else begin
            prdata = 32'(rx_head);
            rx_pop = 1'b1;
          end
        end
        default: err = 1'b1;
      endcase
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err;

  // CTRL register and sticky RX overflow flag
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      ctrl_reg   <= '0;
      rx_ovf_reg <= 1'b0;
    end else begin
      if (ctrl_we) ctrl_reg <= {apb.PWDATA[18:8], 2'b00, apb.PWDATA[5:0]};
      if (ovf_clr) rx_ovf_reg <= 1'b0;
      if (rx_push && rx_full && !rx_pop) rx_ovf_reg <= 1'b1;
    end
  end

  // TX FIFO pointers: APB pushes, engine pops at frame start
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      tx_wr_reg <= '0;
      tx_rd_reg <= '0;
    end else begin
      if (tx_push) tx_wr_reg <= tx_wr_reg + 1'b1;
      if (load)    tx_rd_reg <= tx_rd_reg + 1'b1;
    end
  end

  // TX FIFO storage
  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr_reg[PW-2:0]] <= apb.PWDATA[DATA_W-1:0];
  end

  // RX FIFO: a same-cycle APB pop frees the slot for the engine push
  assign rx_accept = rx_push & (~rx_full | rx_pop);

  // RX FIFO pointers
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      rx_wr_reg <= '0;
      rx_rd_reg <= '0;
    end else begin
      if (rx_accept) rx_wr_reg <= rx_wr_reg + 1'b1;
      if (rx_pop)    rx_rd_reg <= rx_rd_reg + 1'b1;
    end
  end

  // RX FIFO storage
  always_ff @(posedge PCLK) begin
    if (rx_accept) rx_mem[rx_wr_reg[PW-2:0]] <= rx_sh_reg;
  end

  // FSM state register
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  assign half_done = (cnt_reg == div_reg);

  // FSM next state; toggle marks an sck edge whose index is edge_reg
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    toggle     = 1'b0;
    rx_push    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ctrl_en && !tx_empty) begin
          state_next = LEAD;
          load       = 1'b1;
        end
      end
      LEAD: begin
        if (half_done) begin
          state_next = SHIFT;
          toggle     = 1'b1;
        end
      end
      SHIFT: begin
        if (half_done) begin
          if (edge_reg == NUM_EDGES) state_next = TRAIL;
          else                       toggle     = 1'b1;
        end
      end
      TRAIL: begin
        if (half_done) begin
          state_next = GAP;
          rx_push    = 1'b1;
        end
      end
      GAP: begin
        if (half_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Even edge index = leading edge. With CPHA=1 the first bit is already on
  // mosi from frame start, so the first leading edge does not shift.
  assign leading   = ~edge_reg[0];
  assign do_sample = toggle & (leading ^ cpha_lat_reg);
  assign do_shift  = toggle & (cpha_lat_reg ? (leading & (edge_reg != '0)) : ~leading);

  assign tx_shifted   = lsb_lat_reg ? (tx_sh_reg >> 1) : (tx_sh_reg << 1);
  assign mosi_shifted = lsb_lat_reg ? tx_shifted[0] : tx_shifted[DATA_W-1];
  assign rx_shifted   = lsb_lat_reg ? ((rx_sh_reg >> 1) | (DATA_W'(miso) << (DATA_W - 1)))
                                    : ((rx_sh_reg << 1) | DATA_W'(miso));

  // Shift engine: half-period timer, sck/mosi/nss generation and RX capture
  always_ff @(posedge PCLK or posedge PRST) begin
    if (PRST) begin
      cnt_reg      <= '0;
      div_reg      <= '0;
      edge_reg     <= '0;
      cpol_lat_reg <= 1'b0;
      cpha_lat_reg <= 1'b0;
      lsb_lat_reg  <= 1'b0;
      sck_reg      <= 1'b0;
      mosi_reg     <= 1'b0;
      nss_reg      <= '1;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
    end else begin
      cnt_reg <= ((state_reg == IDLE) || half_done) ? 8'd0 : cnt_reg + 8'd1;
      if (load) begin
        cpol_lat_reg <= ctrl_cpol;
        cpha_lat_reg <= ctrl_cpha;
        lsb_lat_reg  <= ctrl_lsb;
        div_reg      <= ctrl_div;
        nss_reg      <= nss_dec;
        sck_reg      <= ctrl_cpol;
        tx_sh_reg    <= tx_head;
        mosi_reg     <= ctrl_lsb ? tx_head[0] : tx_head[DATA_W-1];
        rx_sh_reg    <= '0;
        edge_reg     <= '0;
      end else begin
        if (state_reg == IDLE) sck_reg <= ctrl_cpol;
        if (toggle) begin
          sck_reg  <= ~sck_reg;
          edge_reg <= edge_reg + 7'd1;
        end
        if (do_shift) begin
          tx_sh_reg <= tx_shifted;
          mosi_reg  <= mosi_shifted;
        end
        if (do_sample) rx_sh_reg <= rx_shifted;
        if (rx_push)   nss_reg   <= '1;
      end
    end
  end

  assign sck  = sck_reg;
  assign mosi = mosi_reg;
  assign nss  = nss_reg;
  assign irq  = (ctrl_rxie & ~rx_empty) | (ctrl_txie & tx_empty) | rx_ovf_reg;
endmodule

// File: tb/tb_apb_spi_master_mcs.sv
// Testbench for apb_spi_master_mcs: table-driven mode/order vectors with
// mosi looped back to miso, plus directed FIFO, overflow, error and reset sequences.
module tb_apb_spi_master_mcs;
  logic       PCLK = 1'b0;
  logic       PRST;
  logic       sck, mosi, miso, irq;
  logic [3:0] nss;

  apb_spi_master_mcs_if bus();

  assign miso = mosi;

  apb_spi_master_mcs #(
    .DATA_W(8), .NUM_CS(4), .FIFO_DEPTH(4), .FIFO_DEPTH_W(2)
  ) dut (
    .PCLK(PCLK), .PRST(PRST), .apb(bus),
    .sck(sck), .mosi(mosi), .miso(miso), .nss(nss), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge PCLK) cyc++;

  // Bus-pin monitor, sampled on the falling edge
  int         mon_tog, mon_space_bad, mon_low, mon_frames, mon_nbits, mon_last;
  logic [7:0] mon_bits;
  logic [3:0] mon_nss;
  logic       mon_prev_sck, mon_prev_hi, mon_cpol, mon_cpha;

  always @(negedge PCLK) begin
    if (sck !== mon_prev_sck) begin
      if (mon_tog > 0 && (cyc - mon_last) != 2) mon_space_bad++;
      mon_last = cyc;
      mon_tog++;
      if ((sck != mon_cpol) ^ mon_cpha) begin
        mon_bits = {mon_bits[6:0], mosi};
        mon_nbits++;
      end
    end
    mon_prev_sck = sck;
    if (nss != 4'hF) begin
      mon_low++;
      mon_nss = nss;
      if (mon_prev_hi) mon_frames++;
    end
    mon_prev_hi = (nss == 4'hF);
  end

  task automatic mon_clear(input logic cpol, input logic cpha);
    mon_tog = 0; mon_space_bad = 0; mon_low = 0; mon_frames = 0;
    mon_nbits = 0; mon_last = 0; mon_bits = '0; mon_nss = 4'hF;
    mon_prev_sck = sck; mon_prev_hi = (nss == 4'hF);
    mon_cpol = cpol; mon_cpha = cpha;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge PCLK);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = wdata;
    @(negedge PCLK);
    bus.PENABLE = 1'b1;
    #1;
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    @(posedge PCLK);
    #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] addr, input logic [31:0] data, output logic err);
    logic [31:0] d;
    apb_xfer(1'b1, addr, data, d, err);
  endtask

  task automatic apb_rd(input logic [31:0] addr, output logic [31:0] data, output logic err);
    apb_xfer(1'b0, addr, 32'h0, data, err);
  endtask

  // Poll STATUS until the engine is idle; tx_too also requires TX empty
  task automatic wait_idle(input string name, input logic tx_too, input int budget);
    logic [31:0] st;
    logic        e;
    logic        done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      apb_rd(32'h4, st, e);
      if (!st[0] && (st[2] || !tx_too)) done = 1'b1;
    end
    chk(name, {31'b0, done}, 32'h1);
  endtask

  typedef struct {
    logic       cpol, cpha, lsb;
    logic [2:0] cs;
    logic [7:0] tx, exp_rx, exp_bits;
    logic [3:0] exp_nss;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] rd, st;
  logic        e;
  logic        found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd2, 8'hA5, 8'hA5, 8'hA5, 4'b1011};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 3'd1, 8'h3C, 8'h3C, 8'h3C, 4'b1101};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 3'd0, 8'h3C, 8'h3C, 8'h3C, 4'b1110};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 3'd3, 8'h3C, 8'h3C, 8'h3C, 4'b0111};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd2, 8'h3C, 8'h3C, 8'h3C, 4'b1011};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 3'd0, 8'h96, 8'h96, 8'h69, 4'b1110};

    PRST = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    mon_clear(1'b0, 1'b0);
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_sck", {31'b0, sck}, 32'h0);
    chk("rst_nss", {28'b0, nss}, 32'hF);
    chk("rst_mosi", {31'b0, mosi}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("idle_prdata", bus.PRDATA, 32'h0);
    chk("idle_pslverr", {31'b0, bus.PSLVERR}, 32'h0);
    chk("pready", {31'b0, bus.PREADY}, 32'h1);
    @(negedge PCLK);
    PRST = 1'b0;
    apb_rd(32'h4, rd, e);
    chk("rst_status", rd, 32'h0000_0014);

    // Mode / bit-order vectors, CLKDIV=1, looped back
    for (int i = 0; i < 6; i++) begin
      apb_wr(32'h0, {13'b0, vecs[i].cs, 8'd1, 4'b0, vecs[i].lsb, vecs[i].cpha, vecs[i].cpol, 1'b1}, e);
      chk($sformatf("v%0d_ctrl_err", i), {31'b0, e}, 32'h0);
      @(posedge PCLK);
      #1;
      chk($sformatf("v%0d_sck_idle", i), {31'b0, sck}, {31'b0, vecs[i].cpol});
      mon_clear(vecs[i].cpol, vecs[i].cpha);
      apb_wr(32'h8, {24'b0, vecs[i].tx}, e);
      if (i == 0) begin
        chk("v0_nss_at_E", {28'b0, nss}, 32'hF);
        @(posedge PCLK);
        #1;
        chk("v0_nss_at_E1", {28'b0, nss}, 32'hB);
      end
      wait_idle($sformatf("v%0d_done", i), 1'b1, 100);
      chk($sformatf("v%0d_nss_low_cycles", i), mon_low, 36);
      chk($sformatf("v%0d_nss_value", i), {28'b0, mon_nss}, {28'b0, vecs[i].exp_nss});
      chk($sformatf("v%0d_toggles", i), mon_tog, 16);
      chk($sformatf("v%0d_spacing_bad", i), mon_space_bad, 0);
      chk($sformatf("v%0d_nbits", i), mon_nbits, 8);
      chk($sformatf("v%0d_mosi_bits", i), {24'b0, mon_bits}, {24'b0, vecs[i].exp_bits});
      chk($sformatf("v%0d_sck_end", i), {31'b0, sck}, {31'b0, vecs[i].cpol});
      apb_rd(32'hC, rd, e);
      chk($sformatf("v%0d_rx", i), rd, {24'b0, vecs[i].exp_rx});
      chk($sformatf("v%0d_rx_err", i), {31'b0, e}, 32'h0);
    end

    // FIFO limits
    apb_wr(32'h0, 32'h0002_0100, e);
    for (int i = 0; i < 5; i++) begin
      apb_wr(32'h8, 32'h11 + i, e);
      chk($sformatf("fifo_tx_err%0d", i), {31'b0, e}, (i == 4) ? 32'h1 : 32'h0);
    end
    apb_rd(32'h4, rd, e);
    chk("fifo_tx_status", rd, 32'h0000_0412);
    mon_clear(1'b0, 1'b0);
    apb_wr(32'h0, 32'h0002_0101, e);
    wait_idle("fifo_done", 1'b1, 300);
    chk("fifo_frames", mon_frames, 4);
    chk("fifo_low_cycles", mon_low, 144);
    apb_rd(32'h4, rd, e);
    chk("fifo_rx_status", rd, 32'h0004_000C);
    for (int i = 0; i < 5; i++) begin
      apb_rd(32'hC, rd, e);
      chk($sformatf("fifo_rx%0d", i), rd, (i == 4) ? 32'h0 : 32'h11 + i);
      chk($sformatf("fifo_rx_err%0d", i), {31'b0, e}, (i == 4) ? 32'h1 : 32'h0);
    end

    // Overflow: five frames, no reads
    for (int i = 0; i < 5; i++) begin
      apb_wr(32'h8, 32'h21 + i, e);
      chk($sformatf("ovf_tx_err%0d", i), {31'b0, e}, 32'h0);
    end
    wait_idle("ovf_done", 1'b1, 400);
    apb_rd(32'h4, rd, e);
    chk("ovf_status", rd, 32'h0004_002C);
    chk("ovf_irq", {31'b0, irq}, 32'h1);
    apb_wr(32'h4, 32'h20, e);
    apb_rd(32'h4, rd, e);
    chk("ovf_cleared", rd, 32'h0004_000C);
    chk("ovf_irq_clear", {31'b0, irq}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      apb_rd(32'hC, rd, e);
      chk($sformatf("ovf_rx%0d", i), rd, 32'h21 + i);
    end
    apb_rd(32'h4, rd, e);
    chk("ovf_drained", rd, 32'h0000_0014);

    // Error responses and TXIE
    apb_rd(32'h14, rd, e);
    chk("unmapped_rd_err", {31'b0, e}, 32'h1);
    chk("unmapped_rd_data", rd, 32'h0);
    apb_wr(32'h14, 32'hFFFF_FFFF, e);
    chk("unmapped_wr_err", {31'b0, e}, 32'h1);
    apb_rd(32'h8, rd, e);
    chk("txdata_rd_err", {31'b0, e}, 32'h1);
    apb_wr(32'hC, 32'h1, e);
    chk("rxdata_wr_err", {31'b0, e}, 32'h1);
    apb_wr(32'h0, 32'h0000_0020, e);
    #1;
    chk("txie_irq", {31'b0, irq}, 32'h1);

    // Out-of-range chip select: CTRL updates, frame runs with nss high
    apb_wr(32'h0, 32'h0005_0101, e);
    chk("cs5_err", {31'b0, e}, 32'h1);
    apb_rd(32'h0, rd, e);
    chk("cs5_ctrl", rd, 32'h0005_0101);
    mon_clear(1'b0, 1'b0);
    apb_wr(32'h8, 32'h5A, e);
    wait_idle("cs5_done", 1'b1, 100);
    chk("cs5_frames", mon_frames, 0);
    chk("cs5_toggles", mon_tog, 16);
    apb_rd(32'hC, rd, e);
    chk("cs5_rx", rd, 32'h5A);

    // Clear EN mid-frame: current frame completes, next does not start
    apb_wr(32'h0, 32'h0002_0101, e);
    mon_clear(1'b0, 1'b0);
    apb_wr(32'h8, 32'h77, e);
    apb_wr(32'h8, 32'h78, e);
    repeat (6) @(posedge PCLK);
    apb_wr(32'h0, 32'h0002_0100, e);
    wait_idle("en_clr_done", 1'b0, 100);
    chk("en_clr_low_cycles", mon_low, 36);
    chk("en_clr_toggles", mon_tog, 16);
    repeat (50) @(posedge PCLK);
    chk("en_clr_frames", mon_frames, 1);
    apb_rd(32'h4, rd, e);
    chk("en_clr_status", rd, 32'h0001_0100);
    apb_rd(32'hC, rd, e);
    chk("en_clr_rx", rd, 32'h77);

    // Asynchronous reset mid-frame (mode 2, frame carries 0x78)
    apb_wr(32'h0, 32'h0002_0103, e);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge PCLK);
      if (mosi === 1'b1 && nss == 4'hB) found = 1'b1;
    end
    chk("midrst_found", {31'b0, found}, 32'h1);
    #2;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 32'h4;
    PRST = 1'b1;
    #1;
    chk("midrst_sck", {31'b0, sck}, 32'h0);
    chk("midrst_nss", {28'b0, nss}, 32'hF);
    chk("midrst_mosi", {31'b0, mosi}, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    chk("midrst_status", bus.PRDATA, 32'h0000_0014);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(negedge PCLK);
    PRST = 1'b0;
    apb_rd(32'h0, rd, e);
    chk("midrst_ctrl", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/apb_spi_master_mcs.md
Name: apb_spi_master_mcs

Overview:
Parametrised successor to the single-slave APB SPI master. Adds configurable frame width, multiple chip selects, all four CPOL/CPHA modes, LSB/MSB-first order, a programmable SCK divider, TX/RX FIFOs with status and overflow flags, and a level interrupt. It connects directly to one port of the APB slave mux as a zero-wait-state APB slave.

Parameters:
DATA_W, 8, bits per SPI frame; legal range 1..32.
NUM_CS, 4, number of chip-select outputs; legal range 1..8.
FIFO_DEPTH, 4, entries in each of the TX and RX FIFOs; must be a power of 2.
FIFO_DEPTH_W, 2, log2(FIFO_DEPTH).

Ports:
PCLK  in  1  single clock for the APB side and the SPI engine.
PRST  in  1  reset; asynchronous, active-high.
PADDR  in  32  byte address; only [4:2] decoded.
PWRITE  in  1  APB write.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWDATA  in  32  APB write data.
PRDATA  out  32  read data; 0 when not in a read access phase.
PREADY  out  1  tied to 1 (zero wait states).
PSLVERR  out  1  error flag, asserted only in the access phase.
sck  out  1  SPI clock.
mosi  out  1  SPI data out.
miso  in  1  SPI data in.
nss  out  NUM_CS  active-low chip selects.
irq  out  1  level interrupt.

Behaviour:
- Reset values: sck=0, mosi=0, nss=all 1, irq=0, PSLVERR=0, FIFOs empty, CTRL=0, RX_OVF=0, FSM=IDLE.
- Access: an APB access is PSEL&PENABLE in a given cycle. PREADY is always 1.
- Register map:
  - 0x00 CTRL (RW): [0] EN, [1] CPOL, [2] CPHA, [3] LSB_FIRST, [4] RXIE, [5] TXIE, [15:8] CLKDIV, [18:16] CS_SEL.
  - 0x04 STATUS (RO, except bit 5): [0] BUSY, [1] TX_FULL, [2] TX_EMPTY, [3] RX_FULL, [4] RX_EMPTY, [5] RX_OVF (sticky; write 1 to clear), [15:8] TX level, [23:16] RX level.
  - 0x08 TXDATA (WO): push PWDATA[DATA_W-1:0].
  - 0x0C RXDATA (RO): return the zero-extended head entry and pop it.
- PSLVERR is asserted for:
  - a write to a full TX FIFO (data dropped);
  - a read of an empty RX FIFO (PRDATA=0);
  - an unmapped address (writes ignored, reads return 0);
  - a read of TXDATA;
  - a write to RXDATA;
  - CS_SEL >= NUM_CS on a CTRL write (CTRL still updated; nss stays high for frames started with that value).
- SCK half period = CLKDIV+1 PCLK cycles. Idle level of sck = CPOL.
- FSM:
  - IDLE: if EN and TX not empty, go to LEAD. Next edge: pop TX, latch CPOL/CPHA/LSB_FIRST/CLKDIV/CS_SEL, assert nss[CS_SEL]=0, drive the first bit on mosi.
  - LEAD: lasts 1 half period, then SHIFT.
  - SHIFT: 2*DATA_W sck toggles, one per half period.
    - CPHA=0: sample miso on leading edges, shift mosi on trailing edges.
    - CPHA=1: shift mosi on leading edges, sample miso on trailing edges.
  - TRAIL: 1 half period, sck at idle level, then push the RX word and go to GAP.
  - GAP: nss all 1 for 1 half period, then IDLE.
- Timing: the TXDATA access completes at edge E. The TX FIFO is non-empty after E, and nss goes low after edge E+1. Frame length for DATA_W=8, CLKDIV=1 is 2+32+2+2 = 38 cycles, nss low through LEAD, SHIFT and TRAIL.
- BUSY = FSM not IDLE.
- Bit order: MSB-first unless LSB_FIRST; the same order applies to TX and RX.
- RX push into a full FIFO: the word is dropped and RX_OVF is set. Exception: an APB pop in the same cycle makes room, so the push is accepted and RX_OVF is not set.
- TX push when full with an engine pop in the same cycle: the push is still rejected with PSLVERR.
- Clearing EN mid-frame: the current frame completes; no new frame starts. CTRL writes mid-frame take effect at the next LEAD.
- PRST mid-frame: all outputs immediately take reset values and FIFO contents are lost.
- irq = (RXIE & !RX_EMPTY) | (TXIE & TX_EMPTY) | RX_OVF.
- FIFO pointers are FIFO_DEPTH_W+1 bits wide and wrap; full = MSBs differ and low bits equal.

Test Plan:
1. Reset: PRST=1 mid-frame -> sck=0, nss=4'b1111, mosi=0, STATUS=0x0000_0014 immediately, with no clock edge required.
2. Mode 0, DATA_W=8, CLKDIV=1, CS_SEL=2: write TX 0xA5 with miso looped to mosi -> nss=4'b1011 for 36 cycles, 16 sck toggles at 2-cycle spacing, mosi sequence 1,0,1,0,0,1,0,1, RXDATA reads 0xA5.
3. Modes 1/2/3 and LSB_FIRST: 0x3C looped back -> reads 0x3C; sck idles high when CPOL=1; with LSB_FIRST, mosi bit order is 0,0,1,1,1,1,0,0.
4. FIFO limits: with EN=0, write 5 TX words -> 5th write gets PSLVERR=1 and TX level=4. Set EN -> 4 frames back-to-back, each separated by a GAP. Read RX 5 times -> 5th read gets PSLVERR=1 and PRDATA=0.
5. Overflow: run 5 frames with no reads -> RX_OVF=1 and irq=1; the 5th word is lost. Write STATUS=0x20 -> RX_OVF=0.
6. Errors and config: read 0x14 -> PSLVERR=1, PRDATA=0. CTRL CS_SEL=5 with NUM_CS=4 -> PSLVERR=1 and the frame runs with nss all 1. Clear EN mid-frame -> the frame completes and BUSY falls after GAP.
